// File: rtl/tlul_pkg.sv
// TL-UL channel types plus the queued error-response entry used by the error responders.
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [top_pkg::TL_DW-1:0] DataWhenError = {top_pkg::TL_DW{1'b1}};

  typedef struct packed {
    logic                        a_valid;
    tl_a_op_e                    a_opcode;
    logic [2:0]                  a_param;
    logic [top_pkg::TL_SZW-1:0]  a_size;
    logic [top_pkg::TL_AIW-1:0]  a_source;
    logic [top_pkg::TL_AW-1:0]   a_address;
    logic [top_pkg::TL_DBW-1:0]  a_mask;
    logic [top_pkg::TL_DW-1:0]   a_data;
    logic [top_pkg::TL_AUW-1:0]  a_user;
    logic                        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                        d_valid;
    tl_d_op_e                    d_opcode;
    logic [2:0]                  d_param;
    logic [top_pkg::TL_SZW-1:0]  d_size;
    logic [top_pkg::TL_AIW-1:0]  d_source;
    logic [top_pkg::TL_DIW-1:0]  d_sink;
    logic [top_pkg::TL_DW-1:0]   d_data;
    logic [top_pkg::TL_DUW-1:0]  d_user;
    logic                        d_error;
    logic                        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [top_pkg::TL_AIW-1:0] source;
    logic [top_pkg::TL_SZW-1:0] size;
    tl_a_op_e                   opcode;
  } tl_err_entry_t;

  // Only Get carries data back; every other encoding, legal or not, is acked without data.
  function automatic tl_d_op_e err_resp_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction
endpackage

// File: rtl/top_pkg.sv
// Bus-wide TL-UL geometry shared by every TL-UL block.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_AUW = 4;
  localparam int TL_DUW = 4;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
endpackage

// File: rtl/tlul_err_fifo.sv
// In-order FIFO of pending error-response entries; pointers wrap modulo Depth (any Depth >= 1).
module tlul_err_fifo
  import tlul_pkg::*;
#(
  parameter int Depth = 2,
  parameter int PtrW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  tl_err_entry_t   wdata,
  input  logic            pop,
  output tl_err_entry_t   rdata,
  output logic            full,
  output logic            empty,
  output logic [PtrW-1:0] occupancy
);
  localparam int              IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(Depth - 1);
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(Depth);

  tl_err_entry_t   mem [Depth];
  logic [IdxW-1:0] wptr, rptr;
  logic [PtrW-1:0] count;
  logic            do_push, do_pop;

  assign full      = (count == DepthCnt);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rdata     = mem[rptr];

  // NOTE: storage has no reset; an entry is only read once count says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignment so every reader sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LastIdx) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LastIdx) ? '0 : rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> !full);
  a_occ_bound:    assert property (@(posedge clk_i) disable iff (rst_i) count <= DepthCnt);
endmodule

// File: rtl/tlul_err_resp_mo.sv
// Multi-outstanding TL-UL error responder: queues up to Depth requests, answers each in order
// with d_error=1, and counts accepted requests in a saturating counter.
module tlul_err_resp_mo
  import tlul_pkg::*;
#(
  parameter int                         Depth   = 2,
  parameter logic [top_pkg::TL_DW-1:0]  ErrData = DataWhenError,
  parameter int                         CntW    = 16,
  parameter int                         PtrW    = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t         tl_h_i,
  output tl_d2h_t         tl_h_o,
  input  logic            cnt_clr_i,
  output logic [CntW-1:0] err_cnt_o,
  output logic [PtrW-1:0] occupancy_o
);
  localparam logic [CntW-1:0] CntMax = '1;

  tl_err_entry_t push_entry, head;
  logic          full, empty, accept, respond;

  assign push_entry = '{source: tl_h_i.a_source, size: tl_h_i.a_size, opcode: tl_h_i.a_opcode};
  // a_ready depends on registered occupancy only, so a same-cycle pop never frees a slot.
  assign accept  = tl_h_i.a_valid && !full;
  assign respond = !empty && tl_h_i.d_ready;

  tlul_err_fifo #(.Depth(Depth), .PtrW(PtrW)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (accept),
    .wdata     (push_entry),
    .pop       (respond),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy_o)
  );

  // NOTE: the whole output struct gets a default first so no field can infer a latch.
  always_comb begin
    tl_h_o         = '0;
    tl_h_o.a_ready = !full;
    tl_h_o.d_valid = !empty;
    if (!empty) begin
      tl_h_o.d_opcode = err_resp_opcode(head.opcode);
      tl_h_o.d_size   = head.size;
      tl_h_o.d_source = head.source;
      tl_h_o.d_error  = 1'b1;
      tl_h_o.d_data   = (head.opcode == Get) ? ErrData : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                 err_cnt_o <= '0;
    else if (cnt_clr_i)                        err_cnt_o <= accept ? CntW'(1) : '0;
    else if (accept && (err_cnt_o != CntMax))  err_cnt_o <= err_cnt_o + 1'b1;
  end

  logic unused_fields;
  assign unused_fields = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask,
                           tl_h_i.a_data, tl_h_i.a_user};

  a_dvalid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (tl_h_o.d_valid && !tl_h_i.d_ready) |=> (tl_h_o.d_valid && $stable(head)));
endmodule

// File: doc/tlul_err_resp_mo.md
Name: tlul_err_resp_mo

Overview:
- Multi-outstanding TL-UL error responder, the parametrised successor of the single-pending error responder.
- Placed behind tlul_socket_1n decode-miss ports and IOPMP deny paths.
- Accepts up to Depth requests before back-pressuring and answers each in order with d_error=1.
- Adds a configurable read-data pattern, an occupancy output and a saturating error counter for IOPMP error logging.

Parameters:
- Depth, 2, number of queued error responses (1..16); Depth=1 reproduces the legacy one-pending behaviour.
- ErrData, 32'hFFFF_FFFF, d_data returned for Get; width top_pkg::TL_DW.
- CntW, 16, width of the saturating error counter.
- PtrW, $clog2(Depth+1), derived occupancy width; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- tl_h_i  in  tlul_pkg::tl_h2d_t  host request channel; d_ready used
- tl_h_o  out  tlul_pkg::tl_d2h_t  error response channel; a_ready driven
- cnt_clr_i  in  1  clears err_cnt_o
- err_cnt_o  out  CntW  accepted-request count, saturating at all-ones
- occupancy_o  out  PtrW  number of queued responses

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high; rst_i sampled on the clk_i rising edge.
- While rst_i is high, and in the cycle after it falls:
  - occupancy_o=0, d_valid=0, a_ready=1, err_cnt_o=0.
  - d_source, d_size, d_opcode, d_data = 0.
- Reset mid-operation discards all queued entries; no response is issued for them.
- Accept condition: a_valid && a_ready. Each accepted request pushes {a_source, a_size, a_opcode} into an in-order FIFO.
- a_ready = (occupancy_o != Depth). It is registered-state-only; there is no combinational path from d_ready to a_ready. A push is refused when full even if a pop happens in the same cycle.
- Response timing:
  - d_valid = (occupancy_o != 0); fields come from the FIFO head.
  - Minimum latency is 1 cycle (response visible the cycle after acceptance); there is no same-cycle fall-through.
- Pop condition: d_valid && d_ready.
  - Simultaneous push and pop leaves occupancy unchanged and the head advances.
  - With Depth>=2 and d_ready held high, one request is accepted and one response issued every cycle.
- Response fields:
  - d_opcode = AccessAckData if the stored opcode == Get, else AccessAck. PutFullData, PutPartialData and any illegal encoding all give AccessAck.
  - d_data = ErrData for Get, else 0.
  - d_error=1, d_param=0, d_sink=0, d_size and d_source as stored.
- Response stability: head fields stay stable while d_valid && !d_ready.
- Pointers: read and write pointers wrap modulo Depth; non-power-of-two Depth is legal.
- Error counter:
  - +1 per accept; saturates at 2^CntW-1 and stays there.
  - cnt_clr_i has priority: with clear and accept in the same cycle, err_cnt_o=1 next cycle; clear alone gives 0.
- Unused tl_h_i fields (address, mask, data, user) are ignored.
- Assertions:
  - occupancy_o <= Depth.
  - d_valid must not drop without d_ready.
  - No push when full.

Decomposition:
- In tlul_pkg (shared): typedef tl_err_entry_t {source, size, opcode}, and constant DataWhenError used as the ErrData default.
- One sub-module, tlul_err_fifo: a synchronous Depth-entry FIFO of tl_err_entry_t with push/pop/full/empty/occupancy, same clk_i/rst_i.
- The top level holds the handshake mapping, response formatting and counter.

Test Plan:
- Single Get: Get with source=3, size=2, d_ready=1 -> next cycle d_valid=1, d_opcode=AccessAckData, d_data=FFFF_FFFF, d_error=1, d_source=3, d_size=2; err_cnt_o=1.
- Back-to-back, Depth=2: 4 consecutive PutFullData (sources 0..3) with d_ready=1 -> a_ready stays 1; 4 AccessAck responses in cycles 1..4, sources 0,1,2,3, d_data=0.
- Full stall: Depth=2, d_ready=0, 3 requests -> a_ready=0 after 2 accepts, occupancy_o=2. The third request is held until the first pop and responses return in order. With Depth=1, a_ready and d_valid alternate as in the legacy responder.
- Counter: CntW=4, 17 accepts -> err_cnt_o=15. Then cnt_clr_i with a simultaneous accept -> err_cnt_o=1.
- Reset mid-flight: occupancy_o=2, rst_i pulsed 1 cycle -> next cycle d_valid=0, occupancy_o=0, err_cnt_o=0, a_ready=1; the flushed entries are never responded.
- Illegal opcode 3'h5 with source=7 -> AccessAck, d_error=1, d_data=0, d_source=7.
